// File: rtl/imem_arbiter.sv
// Shares the single-port instruction RAM between core fetch and the host load/debug port; sequences boot/run/halt.
// Latency: grant and RAM drive are combinational; read data returns one cycle after a granted read.
// Backpressure: fetch stalls via cpu_stall; host waits on host_gnt, with a bounded-starvation slot in RUN.
module imem_arbiter #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic              cpu_stall,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rst_n,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   input  logic              host_hold,
   input  logic              boot_done,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [1:0]        state_o
);

   localparam int SW = $clog2(STARVE_MAX + 1);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t          state, state_nx;
   logic [SW-1:0]   starve_cnt, starve_nx;
   logic            host_win, cpu_win, in_run, starve_full;

   assign in_run      = (state == ST_RUN);
   assign starve_full = (starve_cnt == SW'(STARVE_MAX));

   // Pick this cycle's RAM owner: host only outside RUN; in RUN fetch first unless the host has waited long enough.
   always_comb begin
      host_win = 1'b0;
      cpu_win  = 1'b0;
      if (in_run) begin
         host_win = host_req & (~cpu_req | starve_full);
         cpu_win  = cpu_req & ~host_win;
      end else begin
         host_win = host_req;
      end
   end

   assign host_gnt  = host_win;
   assign cpu_stall = in_run ? (cpu_req & ~cpu_win) : 1'b1;

   // Steer the winner onto the RAM port; a fetch never carries write data.
   always_comb begin
      ram_en    = host_win | cpu_win;
      ram_we    = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (host_win) begin
         ram_we    = host_we;
         ram_addr  = host_addr;
         ram_wdata = host_wdata;
      end else if (cpu_win) begin
         ram_addr  = cpu_addr;
      end
   end

   // Next-state and starvation counter: the counter only runs across consecutive denied cycles within one RUN stretch.
   always_comb begin
      state_nx  = state;
      starve_nx = '0;
      case (state)
         ST_BOOT: if (boot_done) state_nx = ST_RUN;
         ST_RUN:  if (host_hold) state_nx = ST_HALT;
         ST_HALT: if (!host_hold) state_nx = ST_RUN;
         default: state_nx = ST_BOOT;
      endcase
      if (in_run && (state_nx == ST_RUN) && host_req && !host_win) begin
         starve_nx = starve_full ? starve_cnt : starve_cnt + SW'(1);
      end
   end

   // State, counter, core reset and read-return flags; reset discards any pending return.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_BOOT;
         starve_cnt  <= '0;
         cpu_rvalid  <= 1'b0;
         host_rvalid <= 1'b0;
         cpu_rst_n   <= 1'b0;
      end else begin
         state       <= state_nx;
         starve_cnt  <= starve_nx;
         cpu_rvalid  <= cpu_win;
         host_rvalid <= host_win & ~host_we;
         cpu_rst_n   <= (state_nx != ST_BOOT);
      end
   end

   assign cpu_rdata  = ram_rdata;
   assign host_rdata = ram_rdata;
   assign state_o    = state;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: table vectors for boot/run, hand sequences for starvation, halt and reset,
// then random traffic checked against a behavioural model with a shadow memory.
// Clock period 10; inputs driven at negedge, outputs sampled 1 time unit later.
module tb_imem_arbiter;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int SM = 4;

   logic          clk = 1'b0;
   logic          rst_n, cpu_req, host_req, host_we, host_hold, boot_done;
   logic [AW-1:0] cpu_addr, host_addr;
   logic [DW-1:0] host_wdata;
   logic          cpu_stall, cpu_rvalid, cpu_rst_n, host_gnt, host_rvalid;
   logic [DW-1:0] cpu_rdata, host_rdata, ram_wdata;
   logic          ram_en, ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_rdata = '0;
   logic [1:0]    state_o;

   logic [DW-1:0] ram    [0:15] = '{default: '0};
   logic [DW-1:0] shadow [0:15] = '{default: '0};

   int n_vec = 0;
   int n_err = 0;

   // model state: 0=BOOT 1=RUN 2=HALT
   int            m_state, m_starve;
   bit            m_crv, m_hrv, m_rstn;
   logic [DW-1:0] m_crd, m_hrd;
   bit            e_hw, e_cw, e_stall;

   imem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_stall(cpu_stall),
      .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_rst_n(cpu_rst_n),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
      .host_hold(host_hold), .boot_done(boot_done),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .state_o(state_o)
   );

   always #5 clk = ~clk;

   // synchronous single-port RAM, one-cycle read latency
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) ram[ram_addr[3:0]] <= ram_wdata;
         else        ram_rdata <= ram[ram_addr[3:0]];
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_check();
      if (m_state == 1) begin
         e_hw    = host_req && (!cpu_req || m_starve == SM);
         e_cw    = cpu_req && !e_hw;
         e_stall = cpu_req && !e_cw;
      end else begin
         e_hw    = host_req;
         e_cw    = 1'b0;
         e_stall = 1'b1;
      end
      chk("m_host_gnt", 32'(host_gnt), 32'(e_hw));
      chk("m_cpu_stall", 32'(cpu_stall), 32'(e_stall));
      chk("m_ram_en", 32'(ram_en), 32'(e_hw || e_cw));
      if (e_hw) begin
         chk("m_ram_we", 32'(ram_we), 32'(host_we));
         chk("m_ram_addr_h", 32'(ram_addr), 32'(host_addr));
         if (host_we) chk("m_ram_wdata_h", ram_wdata, host_wdata);
      end
      if (e_cw) begin
         chk("m_ram_we_c", 32'(ram_we), 32'd0);
         chk("m_ram_addr_c", 32'(ram_addr), 32'(cpu_addr));
         chk("m_ram_wdata_c", ram_wdata, 32'd0);
      end
      chk("m_state", 32'(state_o), 32'(m_state));
      chk("m_cpu_rst_n", 32'(cpu_rst_n), 32'(m_rstn));
      chk("m_cpu_rvalid", 32'(cpu_rvalid), 32'(m_crv));
      chk("m_host_rvalid", 32'(host_rvalid), 32'(m_hrv));
      if (m_crv) chk("m_cpu_rdata", cpu_rdata, m_crd);
      if (m_hrv) chk("m_host_rdata", host_rdata, m_hrd);
   endtask

   task automatic model_update();
      int ns;
      if (!rst_n) begin
         m_state = 0; m_starve = 0; m_crv = 0; m_hrv = 0; m_rstn = 0;
      end else begin
         if (m_state == 0) ns = boot_done ? 1 : 0;
         else              ns = host_hold ? 2 : 1;
         // consecutive denials within one uninterrupted RUN stretch, capped
         if (m_state == 1 && ns == 1 && host_req && !e_hw)
            m_starve = (m_starve + 1 > SM) ? SM : m_starve + 1;
         else
            m_starve = 0;
         m_crv  = e_cw;
         m_crd  = shadow[cpu_addr[3:0]];
         m_hrv  = e_hw && !host_we;
         m_hrd  = shadow[host_addr[3:0]];
         m_rstn = (ns != 0);
         m_state = ns;
      end
      if (e_hw && host_we) shadow[host_addr[3:0]] = host_wdata;
   endtask

   task automatic drive(input bit rst, input bit creq, input int caddr, input bit hreq, input bit hwe,
                        input int haddr, input logic [31:0] hwd, input bit hold, input bit bd);
      @(negedge clk);
      rst_n      = !rst;
      cpu_req    = creq;
      cpu_addr   = AW'(caddr);
      host_req   = hreq;
      host_we    = hwe;
      host_addr  = AW'(haddr);
      host_wdata = hwd;
      host_hold  = hold;
      boot_done  = bd;
      #1;
      model_check();
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
   endtask

   typedef struct {
      bit rst; bit creq; int caddr; bit hreq; bit hwe; int haddr; logic [31:0] hwd; bit hold; bit bd;
      bit gnt; bit stall; int st; bit rstn; bit crv; bit hrv; logic [31:0] rd;
   } vec_t;

   initial begin
      vec_t tbl [11];
      bit   hold_r;
      rst_n = 1'b0; cpu_req = 0; host_req = 0; host_we = 0; host_hold = 0; boot_done = 0;
      cpu_addr = '0; host_addr = '0; host_wdata = '0;
      repeat (2) @(posedge clk);
      m_state = 0; m_starve = 0; m_crv = 0; m_hrv = 0; m_rstn = 0; m_crd = '0; m_hrd = '0;

      //           rst c  ca h we ha hwd           hold bd | gnt stall st rstn crv hrv rd
      tbl[0]  = '{0, 0, 0, 1, 1, 0, 32'h00000013, 0, 0,  1, 1, 0, 0, 0, 0, 32'h0};
      tbl[1]  = '{0, 0, 0, 1, 1, 1, 32'h00500093, 0, 0,  1, 1, 0, 0, 0, 0, 32'h0};
      tbl[2]  = '{0, 0, 0, 1, 1, 2, 32'h0F002173, 0, 0,  1, 1, 0, 0, 0, 0, 32'h0};
      tbl[3]  = '{0, 0, 0, 1, 1, 7, 32'h12345678, 0, 0,  1, 1, 0, 0, 0, 0, 32'h0};
      tbl[4]  = '{0, 0, 0, 1, 0, 7, 32'h0,        0, 0,  1, 1, 0, 0, 0, 0, 32'h0};
      tbl[5]  = '{0, 0, 0, 1, 0, 0, 32'h0,        0, 1,  1, 1, 0, 0, 0, 1, 32'h12345678};
      tbl[6]  = '{0, 1, 0, 0, 0, 0, 32'h0,        0, 0,  0, 0, 1, 1, 0, 1, 32'h00000013};
      tbl[7]  = '{0, 1, 1, 0, 0, 0, 32'h0,        0, 0,  0, 0, 1, 1, 1, 0, 32'h00000013};
      tbl[8]  = '{0, 1, 2, 0, 0, 0, 32'h0,        0, 0,  0, 0, 1, 1, 1, 0, 32'h00500093};
      tbl[9]  = '{0, 0, 0, 1, 0, 1, 32'h0,        0, 0,  1, 0, 1, 1, 1, 0, 32'h0F002173};
      tbl[10] = '{0, 0, 0, 0, 0, 0, 32'h0,        0, 0,  0, 0, 1, 1, 0, 1, 32'h00500093};

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].creq, tbl[i].caddr, tbl[i].hreq, tbl[i].hwe, tbl[i].haddr,
               tbl[i].hwd, tbl[i].hold, tbl[i].bd);
         chk("t_gnt", 32'(host_gnt), 32'(tbl[i].gnt));
         chk("t_stall", 32'(cpu_stall), 32'(tbl[i].stall));
         chk("t_state", 32'(state_o), 32'(tbl[i].st));
         chk("t_cpu_rst_n", 32'(cpu_rst_n), 32'(tbl[i].rstn));
         chk("t_cpu_rvalid", 32'(cpu_rvalid), 32'(tbl[i].crv));
         chk("t_host_rvalid", 32'(host_rvalid), 32'(tbl[i].hrv));
         if (tbl[i].crv) chk("t_cpu_rdata", cpu_rdata, tbl[i].rd);
         if (tbl[i].hrv) chk("t_host_rdata", host_rdata, tbl[i].rd);
         tick();
      end

      // starvation: continuous fetch, host read @2 held; slot every (SM+1)th cycle
      for (int i = 0; i < 10; i++) begin
         drive(0, 1, 0, 1, 0, 2, 32'h0, 0, 0);
         chk("starve_gnt", 32'(host_gnt), 32'(i == SM || i == 2 * SM + 1));
         chk("starve_stall", 32'(cpu_stall), 32'(i == SM || i == 2 * SM + 1));
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
      chk("starve_rvalid", 32'(host_rvalid), 32'd1);
      chk("starve_rdata", host_rdata, 32'h0F002173);
      tick();

      // halt: host denied in last RUN cycle, served from first HALT cycle, then patch @1
      drive(0, 1, 0, 1, 0, 1, 32'h0, 1, 0);
      chk("halt_deny", 32'(host_gnt), 32'd0);
      tick();
      drive(0, 1, 0, 1, 0, 1, 32'h0, 1, 0);
      chk("halt_first_gnt", 32'(host_gnt), 32'd1);
      chk("halt_state", 32'(state_o), 32'd2);
      tick();
      drive(0, 1, 0, 1, 1, 1, 32'hDEADBEEF, 1, 0);
      chk("halt_wr_gnt", 32'(host_gnt), 32'd1);
      chk("halt_stall", 32'(cpu_stall), 32'd1);
      tick();
      drive(0, 1, 0, 1, 0, 1, 32'h0, 1, 0);
      chk("halt_wr_no_rv", 32'(host_rvalid), 32'd0);
      tick();
      drive(0, 1, 0, 0, 0, 0, 32'h0, 1, 0);
      chk("halt_rd_rv", 32'(host_rvalid), 32'd1);
      chk("halt_rd_data", host_rdata, 32'hDEADBEEF);
      tick();
      drive(0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
      chk("halt_still", 32'(state_o), 32'd2);
      tick();
      drive(0, 1, 1, 0, 0, 0, 32'h0, 0, 0);
      chk("resume_state", 32'(state_o), 32'd1);
      chk("resume_stall", 32'(cpu_stall), 32'd0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
      chk("patched_rv", 32'(cpu_rvalid), 32'd1);
      chk("patched_data", cpu_rdata, 32'hDEADBEEF);
      tick();

      // reset with a fetch granted in the same cycle; pending return discarded
      drive(1, 1, 0, 0, 0, 0, 32'h0, 0, 1);
      chk("rst_fetch_win", 32'(cpu_stall), 32'd0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 32'h0, 1, 0);
      chk("rst_rvalid", 32'(cpu_rvalid), 32'd0);
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_core", 32'(cpu_rst_n), 32'd0);
      tick();
      drive(0, 0, 0, 0, 0, 0, 32'h0, 1, 0);
      chk("boot_hold_ignored", 32'(state_o), 32'd0);
      tick();

      // random traffic against the model
      hold_r = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 29) == 0) hold_r = !hold_r;
         drive($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15),
               $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 3, $urandom_range(0, 15),
               $urandom, hold_r, $urandom_range(0, 19) == 0);
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
